// File: rtl/code_pkg.sv
// Shared code constants, FSM states and event payload for the 3-bit code
// generator and its downstream sequence checker.
package code_pkg;

   localparam int unsigned CODE_W     = 3;
   localparam int unsigned CNT_W      = 8;
   localparam int unsigned ERR_W      = 8;
   localparam int unsigned FIFO_DEPTH = 4;

   localparam logic [CODE_W-1:0] SYNC_A = 3'b101;
   localparam logic [CODE_W-1:0] SYNC_B = 3'b111;
   localparam logic [CODE_W-1:0] IDLE_C = 3'b000;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      GOT_A  = 2'd1,
      LOCKED = 2'd2
   } state_e;

   typedef struct packed {
      logic             err;
      logic [CNT_W-1:0] run;
   } evt_t;

   localparam int unsigned EVT_W = $bits(evt_t);

   // Run counter increment that holds at all-ones.
   function automatic logic [CNT_W-1:0] run_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Error counter increment that holds at all-ones.
   function automatic logic [ERR_W-1:0] err_inc(input logic [ERR_W-1:0] v);
      return (&v) ? v : v + ERR_W'(1);
   endfunction

endpackage

// File: rtl/evt_fifo.sv
// Synchronous FIFO with registered head entry, registered valid and full.
// Pointers carry one extra bit so full and empty are told apart.
module evt_fifo #(
   parameter int unsigned W     = 9,
   parameter int unsigned DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] din,
   output logic         full,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         valid
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic [AW:0]   wr_ptr_nxt;
   logic [AW:0]   rd_ptr_nxt;
   logic [AW-1:0] rd_idx_next;
   logic [W-1:0]  head_nxt;
   logic          wr_en;
   logic          rd_en;
   logic          more_c;

   // Next pointers and the entry that becomes the head after this edge.
   always_comb begin
      rd_en       = pop && valid;
      wr_en       = push && (!full || rd_en);
      wr_ptr_nxt  = wr_ptr + (AW+1)'(wr_en);
      rd_ptr_nxt  = rd_ptr + (AW+1)'(rd_en);
      rd_idx_next = rd_ptr[AW-1:0] + AW'(1);
      more_c      = (rd_ptr + (AW+1)'(1)) != wr_ptr;
      head_nxt    = dout;
      if (rd_en) begin
         if (more_c) begin
            head_nxt = mem[rd_idx_next];
         end else if (wr_en) begin
            head_nxt = din;
         end
      end else if (!valid && wr_en) begin
         head_nxt = din;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr[AW-1:0]] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         dout   <= '0;
         valid  <= 1'b0;
         full   <= 1'b0;
      end else begin
         wr_ptr <= wr_ptr_nxt;
         rd_ptr <= rd_ptr_nxt;
         dout   <= head_nxt;
         valid  <= wr_ptr_nxt != rd_ptr_nxt;
         full   <= (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                   (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
      end
   end

endmodule

// File: rtl/code_seq_checker.sv
// Locks onto the SYNC_A/SYNC_B pair, measures IDLE_C runs while locked and
// reports each completed run or protocol error through an event FIFO.
module code_seq_checker
   import code_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CODE_W-1:0] code_in,
   input  logic              code_vld,
   output logic              evt_valid,
   input  logic              evt_ready,
   output logic [CNT_W-1:0]  evt_run,
   output logic              evt_err,
   output logic              sync_lock,
   output logic [ERR_W-1:0]  err_cnt,
   output logic              ovf
);

   state_e           state;
   state_e           state_nxt;
   logic [CNT_W-1:0] run_cnt;
   logic [CNT_W-1:0] run_nxt;
   logic             push_c;
   logic             err_c;
   logic             pop_c;
   logic             drop_c;
   logic             fifo_full;
   evt_t             push_evt_c;
   evt_t             head;

   // Next-state logic; the FSM only moves on qualified samples.
   always_comb begin
      state_nxt = state;
      run_nxt   = run_cnt;
      push_c    = 1'b0;
      err_c     = 1'b0;
      if (code_vld) begin
         case (state)
            HUNT: begin
               if (code_in == SYNC_A) begin
                  state_nxt = GOT_A;
               end
            end
            GOT_A: begin
               if (code_in == SYNC_B) begin
                  state_nxt = LOCKED;
                  run_nxt   = '0;
               end else if (code_in != SYNC_A) begin
                  state_nxt = HUNT;
               end
            end
            LOCKED: begin
               if (code_in == IDLE_C) begin
                  run_nxt = run_inc(run_cnt);
               end else if (code_in == SYNC_A) begin
                  push_c    = 1'b1;
                  state_nxt = GOT_A;
               end else begin
                  push_c    = 1'b1;
                  err_c     = 1'b1;
                  state_nxt = HUNT;
               end
            end
            default: begin
               state_nxt = HUNT;
            end
         endcase
      end
   end

   // Event payload and FIFO handshake; a push into a full FIFO with no
   // concurrent pop is lost.
   always_comb begin
      push_evt_c     = '0;
      push_evt_c.err = err_c;
      push_evt_c.run = run_cnt;
      pop_c          = evt_valid && evt_ready;
      drop_c         = push_c && fifo_full && !pop_c;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= HUNT;
         run_cnt   <= '0;
         sync_lock <= 1'b0;
         err_cnt   <= '0;
         ovf       <= 1'b0;
      end else begin
         state     <= state_nxt;
         run_cnt   <= run_nxt;
         sync_lock <= (state_nxt == LOCKED);
         if (err_c) begin
            err_cnt <= err_inc(err_cnt);
         end
         if (drop_c) begin
            ovf <= 1'b1;
         end
      end
   end

   evt_fifo #(
      .W     (EVT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_evt_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_c),
      .din   (push_evt_c),
      .full  (fifo_full),
      .pop   (pop_c),
      .dout  (head),
      .valid (evt_valid)
   );

   assign evt_run = head.run;
   assign evt_err = head.err;

endmodule

// File: tb/tb_code_seq_checker.sv
// Table-driven bench for code_seq_checker with an event scoreboard.
module tb_code_seq_checker;
   import code_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [CODE_W-1:0] code_in;
   logic              code_vld;
   logic              evt_valid;
   logic              evt_ready;
   logic [CNT_W-1:0]  evt_run;
   logic              evt_err;
   logic              sync_lock;
   logic [ERR_W-1:0]  err_cnt;
   logic              ovf;

   always #5 clk = ~clk;

   code_seq_checker dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .code_in   (code_in),
      .code_vld  (code_vld),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .evt_run   (evt_run),
      .evt_err   (evt_err),
      .sync_lock (sync_lock),
      .err_cnt   (err_cnt),
      .ovf       (ovf)
   );

   typedef struct {
      logic [2:0] code;
      logic       vld;
      logic       rdy;
      logic       pe;
      logic [7:0] prun;
      logic       perr;
      logic       lock;
   } vec_t;

   vec_t vecs[$];
   evt_t sb[$];
   int   n_vec = 0;
   int   n_bad = 0;
   int   err_exp = 0;
   logic ovf_exp = 1'b0;

   function automatic vec_t row(input logic [2:0] c, input logic vl,
                                input logic rd, input logic lk);
      vec_t v;
      v.code = c; v.vld = vl; v.rdy = rd; v.pe = 1'b0;
      v.prun = 8'd0; v.perr = 1'b0; v.lock = lk;
      return v;
   endfunction

   function automatic vec_t ev(input logic [2:0] c, input logic rd,
                               input logic [7:0] run, input logic er,
                               input logic lk);
      vec_t v;
      v.code = c; v.vld = 1'b1; v.rdy = rd; v.pe = 1'b1;
      v.prun = run; v.perr = er; v.lock = lk;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic apply(input vec_t v);
      evt_t e;
      @(negedge clk);
      code_in   = v.code;
      code_vld  = v.vld;
      evt_ready = v.rdy;
      if (evt_valid && evt_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_event", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("pop_run", int'(evt_run), int'(e.run));
            chk("pop_err", int'(evt_err), int'(e.err));
         end
      end
      @(posedge clk);
      #1;
      if (v.pe) begin
         if (v.perr && err_exp < 255) err_exp++;
         if (sb.size() < FIFO_DEPTH) begin
            e.err = v.perr;
            e.run = v.prun;
            sb.push_back(e);
         end else begin
            ovf_exp = 1'b1;
         end
      end
      chk("sync_lock", int'(sync_lock), int'(v.lock));
      chk("evt_valid", int'(evt_valid), int'(sb.size() != 0));
      chk("ovf", int'(ovf), int'(ovf_exp));
      chk("err_cnt", int'(err_cnt), err_exp);
      if (sb.size() != 0 && evt_valid) begin
         chk("head_run", int'(evt_run), int'(sb[0].run));
         chk("head_err", int'(evt_err), int'(sb[0].err));
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      code_vld  = 1'b0;
      evt_ready = 1'b0;
      code_in   = 3'b000;
      @(posedge clk);
      #1;
      sb.delete();
      err_exp = 0;
      ovf_exp = 1'b0;
      chk("rst_evt_valid", int'(evt_valid), 0);
      chk("rst_evt_run", int'(evt_run), 0);
      chk("rst_evt_err", int'(evt_err), 0);
      chk("rst_sync_lock", int'(sync_lock), 0);
      chk("rst_err_cnt", int'(err_cnt), 0);
      chk("rst_ovf", int'(ovf), 0);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n     = 1'b0;
      code_in   = 3'b000;
      code_vld  = 1'b0;
      evt_ready = 1'b0;
      do_reset();

      // Lock and run of three fill codes
      vecs.push_back(row(3'b101, 1'b1, 1'b1, 1'b0));
      vecs.push_back(row(3'b111, 1'b1, 1'b1, 1'b1));
      vecs.push_back(row(3'b000, 1'b1, 1'b1, 1'b1));
      vecs.push_back(row(3'b000, 1'b1, 1'b1, 1'b1));
      vecs.push_back(row(3'b000, 1'b1, 1'b1, 1'b1));
      vecs.push_back(ev (3'b101, 1'b1, 8'd3, 1'b0, 1'b0));
      vecs.push_back(row(3'b010, 1'b1, 1'b1, 1'b0));
      // Protocol error
      vecs.push_back(row(3'b101, 1'b1, 1'b1, 1'b0));
      vecs.push_back(row(3'b111, 1'b1, 1'b1, 1'b1));
      vecs.push_back(row(3'b000, 1'b1, 1'b1, 1'b1));
      vecs.push_back(ev (3'b110, 1'b1, 8'd1, 1'b1, 1'b0));
      vecs.push_back(row(3'b010, 1'b1, 1'b1, 1'b0));
      // Backpressure: five frames into a four-entry FIFO
      for (int f = 0; f < 5; f++) begin
         vecs.push_back(row(3'b101, 1'b1, 1'b0, 1'b0));
         vecs.push_back(row(3'b111, 1'b1, 1'b0, 1'b1));
         vecs.push_back(row(3'b000, 1'b1, 1'b0, 1'b1));
         vecs.push_back(ev (3'b101, 1'b0, 8'd1, 1'b0, 1'b0));
      end
      // Full FIFO: pop and push on the same edge
      vecs.push_back(row(3'b111, 1'b1, 1'b0, 1'b1));
      vecs.push_back(row(3'b000, 1'b1, 1'b0, 1'b1));
      vecs.push_back(row(3'b000, 1'b1, 1'b0, 1'b1));
      vecs.push_back(ev (3'b101, 1'b1, 8'd2, 1'b0, 1'b0));
      for (int i = 0; i < 5; i++) vecs.push_back(row(3'b110, 1'b0, 1'b1, 1'b0));
      // code_vld gating freezes the run
      vecs.push_back(row(3'b101, 1'b1, 1'b1, 1'b0));
      vecs.push_back(row(3'b111, 1'b1, 1'b1, 1'b1));
      vecs.push_back(row(3'b000, 1'b1, 1'b1, 1'b1));
      for (int i = 0; i < 10; i++) vecs.push_back(row(3'b110, 1'b0, 1'b1, 1'b1));
      vecs.push_back(ev (3'b101, 1'b1, 8'd1, 1'b0, 1'b0));
      vecs.push_back(row(3'b010, 1'b1, 1'b1, 1'b0));

      foreach (vecs[i]) apply(vecs[i]);

      // Upstream free-run: the run counter saturates
      do_reset();
      apply(row(3'b101, 1'b1, 1'b1, 1'b0));
      apply(row(3'b111, 1'b1, 1'b1, 1'b1));
      for (int i = 0; i < 298; i++) apply(row(3'b000, 1'b1, 1'b1, 1'b1));
      apply(ev (3'b101, 1'b1, 8'd255, 1'b0, 1'b0));
      apply(row(3'b010, 1'b1, 1'b1, 1'b0));

      // Reset in the middle of a run discards it
      apply(row(3'b101, 1'b1, 1'b1, 1'b0));
      apply(row(3'b111, 1'b1, 1'b1, 1'b1));
      apply(row(3'b000, 1'b1, 1'b1, 1'b1));
      apply(row(3'b000, 1'b1, 1'b1, 1'b1));
      do_reset();
      apply(row(3'b101, 1'b1, 1'b1, 1'b0));
      apply(row(3'b111, 1'b1, 1'b1, 1'b1));
      apply(ev (3'b101, 1'b1, 8'd0, 1'b0, 1'b0));
      apply(row(3'b010, 1'b1, 1'b1, 1'b0));
      apply(row(3'b010, 1'b1, 1'b1, 1'b0));

      chk("scoreboard_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/code_seq_checker.md
Name: code_seq_checker

Overview:
- Downstream consumer of the 3-bit code generator's output.
- Hunts for the sync pair 101 then 111, and while locked counts the run of 000 codes until the next frame start.
- Reports each completed run, or a protocol error, as an event through a 4-entry valid/ready FIFO to the status/debug logic.
- The generator updates its output on the falling edge of clk; this block samples on the rising edge, giving a half-cycle setup margin.

Parameters:
- CODE_W, 3, width of code_in.
- CNT_W, 8, width of the run counter and evt_run.
- FIFO_DEPTH, 4, event FIFO entries (power of 2, minimum 2).
- SYNC_A, 3'b101, first sync code.
- SYNC_B, 3'b111, second sync code.
- IDLE_C, 3'b000, run (fill) code.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- code_in  in  CODE_W  code from the upstream generator.
- code_vld  in  1  sample enable; code_in is ignored when low.
- evt_valid  out  1  FIFO head holds an event.
- evt_ready  in  1  consumer accepts the head event.
- evt_run  out  CNT_W  IDLE_C run length of the head event.
- evt_err  out  1  head event is a protocol error.
- sync_lock  out  1  FSM is in LOCKED.
- err_cnt  out  8  saturating count of error events.
- ovf  out  1  sticky: an event was dropped because the FIFO was full.

Behaviour:
- Reset (rst_n low at a rising edge):
  - state=HUNT, run_cnt=0, FIFO emptied.
  - evt_valid=0, evt_run=0, evt_err=0, sync_lock=0, err_cnt=0, ovf=0.
  - Reset during an active run discards the run; no event is emitted.
- FSM, which advances only on edges where code_vld=1:
  - HUNT:
    - code==SYNC_A goes to GOT_A.
    - Any other code stays in HUNT.
  - GOT_A:
    - code==SYNC_B goes to LOCKED and clears run_cnt.
    - code==SYNC_A stays in GOT_A.
    - Any other code goes to HUNT with no event.
  - LOCKED:
    - code==IDLE_C: run_cnt+1, saturating at 2^CNT_W-1.
    - code==SYNC_A: push {run=run_cnt, err=0}, go to GOT_A.
    - Any other code (including SYNC_B): push {run=run_cnt, err=1}, go to HUNT, err_cnt+1 saturating at 255.
- sync_lock is registered and equals (state==LOCKED) after each edge.
- Event latency:
  - The push happens at the same rising edge that samples the terminating code.
  - evt_valid is high in the following cycle when the FIFO was empty. There is no combinational bypass.
- FIFO:
  - A pop occurs at a rising edge where evt_valid && evt_ready.
  - evt_run and evt_err are the registered head entry and stay stable while evt_valid=1 and evt_ready=0.
  - Full with push and no pop: the event is dropped, ovf is set, and ovf stays set until reset. err_cnt still increments for a dropped error event.
  - Full with push and pop at the same edge: both happen, no drop, occupancy unchanged.
  - Empty with push and pop: a pop cannot occur because evt_valid=0; the push lands.
  - Read and write pointers wrap modulo FIFO_DEPTH. Full/empty is resolved with one extra pointer bit.
- code_vld=0 freezes the FSM and run_cnt. The FIFO still drains.

Decomposition:
- Shared package code_pkg:
  - typedef of the state enum {HUNT, GOT_A, LOCKED}.
  - constants SYNC_A, SYNC_B, IDLE_C.
  - event struct {err, run}.
  - The upstream generator reuses the same code constants.
- One sub-module, evt_fifo: a synchronous FIFO parameterised by width and depth, with push/full/pop/empty and registered outputs.
- FSM, run counter, err_cnt and ovf live in the top level.

Test Plan:
- Lock and run:
  - Stimulus: code_vld=1, codes 101,111,000,000,000,101 with evt_ready=1.
  - Expected: sync_lock high after the 111 edge; one event run=3 err=0; evt_valid high exactly one cycle after the final 101 edge.
- Upstream free-run:
  - Stimulus: drive the generator's sequence 101,111,000,000,... for 300 cycles, then force 101.
  - Expected: run saturates and the event reports run=255 err=0.
- Error:
  - Stimulus: 101,111,000,110.
  - Expected: event run=1 err=1; state returns to HUNT; sync_lock=0; err_cnt=1.
- Backpressure and overflow:
  - Stimulus: evt_ready=0; generate 5 frames (101,111,000,101 repeated).
  - Expected: 4 events held with the head stable; the 5th is dropped and ovf=1.
  - Then raise evt_ready with a simultaneous push: the pop and push both complete, occupancy stays 4, and ovf stays 1.
- Reset mid-run:
  - Stimulus: lock, two 000 codes, rst_n=0 for one edge, then 101,111,101.
  - Expected: all outputs are at reset values after the reset edge; the first event after reset is run=0 err=0.
- code_vld gating:
  - Stimulus: 101,111,000, then code_vld=0 for 10 cycles while driving 110, then code_vld=1 with 101.
  - Expected: no error event; one event run=1 err=0.
